// File: rtl/end_part_pkg.sv
// Shared types and widths for the end-part write path.
// Widths here must match the packed per-engine request buses.
package end_part_pkg;

  localparam int STRIP_ID_W = 4;
  localparam int WIDTH_W    = 8;
  localparam int STRIKE_W   = 4;
  localparam int GRANT_W    = 3;
  localparam int LOCK_W     = 3;

  localparam logic [WIDTH_W-1:0] STRIP_WIDTH = 8'd128;

  typedef logic [STRIP_ID_W-1:0] strip_id_t;
  typedef logic [WIDTH_W-1:0]    occ_width_t;
  typedef logic [STRIKE_W-1:0]   strike_cnt_t;

  typedef struct packed {
    logic        strike_flag;
    strip_id_t   strip_id;
    occ_width_t  old_width;
    occ_width_t  new_width;
    strike_cnt_t strike_cnt;
  } place_result_t;

endpackage

// File: rtl/end_part_write_scheduler_rr_arbiter.sv
// Round-robin picker: first eligible requester at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none of its own; an ineligible requester is simply skipped.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      idx = sum[IDX_W-1:0];
      if (!grant_vld && elig[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/end_part_write_scheduler.sv
// Shares the end-part write port between NUM_REQ engines; round-robin with per-strip hazard gap (END_PART_WIDTH_CHECK_EN adds width check).
// Latency: accepted fields appear on the write outputs one cycle after the handshake.
// Backpressure: req_ready is low while disabled, while the strip is locked, or while another engine holds the grant.
module end_part_write_scheduler
  import end_part_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int NUM_STRIPS    = 16,
  parameter int HAZARD_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sched_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_strike_flag,
  input  logic [STRIP_ID_W*NUM_REQ-1:0] req_strip_ID,
  input  logic [WIDTH_W*NUM_REQ-1:0]    req_old_width,
  input  logic [WIDTH_W*NUM_REQ-1:0]    req_new_width,
  input  logic [STRIKE_W*NUM_REQ-1:0]   req_strike_counter,
  output logic                          write_valid,
  output logic                          strike_flag_write,
  output logic [STRIP_ID_W-1:0]         strip_ID_write,
  output logic [WIDTH_W-1:0]            old_occupied_width_write,
  output logic [WIDTH_W-1:0]            new_occupied_width_write,
  output logic [STRIKE_W-1:0]           strike_counter_write,
  output logic [GRANT_W-1:0]            grant_id,
  output logic [15:0]                   grant_count,
  output logic                          err_flag
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // The counter holds the number of cycles the strip is still blocked, so a
  // gap of 1 loads 0 and allows back-to-back grants to one strip.
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(HAZARD_CYCLES - 1);

  place_result_t        req_res [NUM_REQ];
  place_result_t        sel_res;
  place_result_t        out_q;
  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic                 accept;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     rr_ptr_nxt;
  logic [LOCK_W-1:0]    lock_cnt [NUM_STRIPS];
  logic                 write_valid_q;
  logic [GRANT_W-1:0]   grant_id_q;
  logic [15:0]          grant_count_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_res[i].strike_flag = req_strike_flag[i];
      req_res[i].strip_id    = req_strip_ID[STRIP_ID_W*i +: STRIP_ID_W];
      req_res[i].old_width   = req_old_width[WIDTH_W*i +: WIDTH_W];
      req_res[i].new_width   = req_new_width[WIDTH_W*i +: WIDTH_W];
      req_res[i].strike_cnt  = req_strike_counter[STRIKE_W*i +: STRIKE_W];
      elig[i] = req_valid[i] && sched_en && (lock_cnt[req_res[i].strip_id] == '0);
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .elig      (elig),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (gnt_idx),
    .grant_vld (gnt_vld)
  );

  assign req_ready  = grant;
  assign accept     = |(req_valid & grant);
  assign sel_res    = req_res[gnt_idx];
  assign rr_ptr_nxt = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      write_valid_q <= 1'b0;
      out_q         <= '0;
      grant_id_q    <= '0;
      grant_count_q <= '0;
      rr_ptr        <= '0;
    end else begin
      write_valid_q <= accept;
      if (accept) begin
        out_q         <= sel_res;
        grant_id_q    <= GRANT_W'(gnt_idx);
        grant_count_q <= grant_count_q + 16'd1;
        rr_ptr        <= rr_ptr_nxt;
      end
    end
  end

  // Reload on accept beats the per-cycle decrement for that strip.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_STRIPS; s++) begin
      if (rst) begin
        lock_cnt[s] <= '0;
      end else if (accept && (sel_res.strip_id == STRIP_ID_W'(s))) begin
        lock_cnt[s] <= LOCK_LOAD;
      end else if (lock_cnt[s] != '0) begin
        lock_cnt[s] <= lock_cnt[s] - LOCK_W'(1);
      end
    end
  end

`ifdef END_PART_WIDTH_CHECK_EN
  logic err_q;

  // Flag-only check: a shrinking or oversize width is still written through.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && ((sel_res.new_width < sel_res.old_width) ||
                            (sel_res.new_width > STRIP_WIDTH))) begin
      err_q <= 1'b1;
    end
  end

  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

  assign write_valid              = write_valid_q;
  assign strike_flag_write        = out_q.strike_flag;
  assign strip_ID_write           = out_q.strip_id;
  assign old_occupied_width_write = out_q.old_width;
  assign new_occupied_width_write = out_q.new_width;
  assign strike_counter_write     = out_q.strike_cnt;
  assign grant_id                 = grant_id_q;
  assign grant_count              = grant_count_q;

endmodule

// File: tb/tb_end_part_write_scheduler.sv
// Directed bench for end_part_write_scheduler: reset, single, round robin, hazard gap, reset mid-stream, sched_en, width check.
module tb_end_part_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        sched_en;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_strike_flag;
  logic [15:0] req_strip_ID;
  logic [31:0] req_old_width;
  logic [31:0] req_new_width;
  logic [15:0] req_strike_counter;
  logic        write_valid;
  logic        strike_flag_write;
  logic [3:0]  strip_ID_write;
  logic [7:0]  old_occupied_width_write;
  logic [7:0]  new_occupied_width_write;
  logic [3:0]  strike_counter_write;
  logic [2:0]  grant_id;
  logic [15:0] grant_count;
  logic        err_flag;

  int total = 0;
  int bad   = 0;

`ifdef END_PART_WIDTH_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic [3:0] rr_strip [4];
  logic [3:0] hz_rdy   [4];
  logic       hz_wv    [4];
  logic [2:0] hz_gid   [4];
  logic [3:0] hz_strip [4];
  logic [7:0] hz_nw    [4];
  logic [15:0] hz_cnt  [4];

  end_part_write_scheduler dut (
    .clk                      (clk),
    .rst                      (rst),
    .sched_en                 (sched_en),
    .req_valid                (req_valid),
    .req_ready                (req_ready),
    .req_strike_flag          (req_strike_flag),
    .req_strip_ID             (req_strip_ID),
    .req_old_width            (req_old_width),
    .req_new_width            (req_new_width),
    .req_strike_counter       (req_strike_counter),
    .write_valid              (write_valid),
    .strike_flag_write        (strike_flag_write),
    .strip_ID_write           (strip_ID_write),
    .old_occupied_width_write (old_occupied_width_write),
    .new_occupied_width_write (new_occupied_width_write),
    .strike_counter_write     (strike_counter_write),
    .grant_id                 (grant_id),
    .grant_count              (grant_count),
    .err_flag                 (err_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int e, input logic [3:0] strip, input logic [7:0] ow,
                         input logic [7:0] nw, input logic [3:0] cnt, input logic sf);
    req_valid[e]                = 1'b1;
    req_strip_ID[4*e +: 4]      = strip;
    req_old_width[8*e +: 8]     = ow;
    req_new_width[8*e +: 8]     = nw;
    req_strike_counter[4*e +: 4] = cnt;
    req_strike_flag[e]          = sf;
  endtask

  task automatic clr(input int e);
    req_valid[e] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (write_valid !== 1'b0) begin bad++; $display("FAIL reset_wv got=%b exp=0", write_valid); end
    total++; if (grant_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", grant_count); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
    total++; if (strip_ID_write !== 4'd0) begin bad++; $display("FAIL reset_strip got=%0d exp=0", strip_ID_write); end
    total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_flag); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_req(0, 4'd1, 8'd0, 8'd16, 4'd1, 1'b1);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    tick();
    clr(0);
    total++; if (write_valid !== 1'b1) begin bad++; $display("FAIL single_wv got=%b exp=1", write_valid); end
    total++; if (strip_ID_write !== 4'd1) begin bad++; $display("FAIL single_strip got=%0d exp=1", strip_ID_write); end
    total++; if (new_occupied_width_write !== 8'd16) begin bad++; $display("FAIL single_nw got=%0d exp=16", new_occupied_width_write); end
    total++; if (old_occupied_width_write !== 8'd0) begin bad++; $display("FAIL single_ow got=%0d exp=0", old_occupied_width_write); end
    total++; if (strike_counter_write !== 4'd1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", strike_counter_write); end
    total++; if (strike_flag_write !== 1'b1) begin bad++; $display("FAIL single_sf got=%b exp=1", strike_flag_write); end
    total++; if (grant_count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", grant_count); end
    tick();
    total++; if (write_valid !== 1'b0) begin bad++; $display("FAIL single_idle_wv got=%b exp=0", write_valid); end
    total++; if (strip_ID_write !== 4'd1) begin bad++; $display("FAIL single_hold_strip got=%0d exp=1", strip_ID_write); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 0; e < 4; e++) set_req(e, rr_strip[e], 8'd10, 8'(20 + e), 4'(e), 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (req_ready !== (4'b0001 << k)) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, 4'b0001 << k); end
      tick();
      clr(k);
      total++; if (grant_id !== 3'(k)) begin bad++; $display("FAIL rr_gid[%0d] got=%0d exp=%0d", k, grant_id, k); end
      total++; if (strip_ID_write !== rr_strip[k]) begin bad++; $display("FAIL rr_strip[%0d] got=%0d exp=%0d", k, strip_ID_write, rr_strip[k]); end
      total++; if (grant_count !== 16'(k + 1)) begin bad++; $display("FAIL rr_count[%0d] got=%0d exp=%0d", k, grant_count, k + 1); end
      total++; if (write_valid !== 1'b1) begin bad++; $display("FAIL rr_wv[%0d] got=%b exp=1", k, write_valid); end
    end
  endtask

  task automatic test_hazard();
    repeat (4) tick();
    set_req(0, 4'd5, 8'd0, 8'd50, 4'd0, 1'b0);
    set_req(1, 4'd5, 8'd0, 8'd51, 4'd0, 1'b0);
    set_req(2, 4'd8, 8'd0, 8'd80, 4'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (req_ready !== hz_rdy[c]) begin bad++; $display("FAIL hz_ready[%0d] got=%b exp=%b", c, req_ready, hz_rdy[c]); end
      tick();
      if (hz_wv[c]) clr(int'(hz_gid[c]));
      total++; if (write_valid !== hz_wv[c]) begin bad++; $display("FAIL hz_wv[%0d] got=%b exp=%b", c, write_valid, hz_wv[c]); end
      total++; if (grant_count !== hz_cnt[c]) begin bad++; $display("FAIL hz_count[%0d] got=%0d exp=%0d", c, grant_count, hz_cnt[c]); end
      total++; if (grant_id !== hz_gid[c]) begin bad++; $display("FAIL hz_gid[%0d] got=%0d exp=%0d", c, grant_id, hz_gid[c]); end
      total++; if (strip_ID_write !== hz_strip[c]) begin bad++; $display("FAIL hz_strip[%0d] got=%0d exp=%0d", c, strip_ID_write, hz_strip[c]); end
      total++; if (new_occupied_width_write !== hz_nw[c]) begin bad++; $display("FAIL hz_nw[%0d] got=%0d exp=%0d", c, new_occupied_width_write, hz_nw[c]); end
    end
  endtask

  task automatic test_reset_mid();
    set_req(2, 4'd3, 8'd1, 8'd33, 4'd2, 1'b0);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rstmid_ready got=%b exp=0100", req_ready); end
    rst = 1'b1;
    tick();
    total++; if (write_valid !== 1'b0) begin bad++; $display("FAIL rstmid_wv got=%b exp=0", write_valid); end
    total++; if (grant_count !== 16'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", grant_count); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL rstmid_gid got=%0d exp=0", grant_id); end
    total++; if (new_occupied_width_write !== 8'd0) begin bad++; $display("FAIL rstmid_nw got=%0d exp=0", new_occupied_width_write); end
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rstmid_reready got=%b exp=0100", req_ready); end
    tick();
    clr(2);
    total++; if (write_valid !== 1'b1) begin bad++; $display("FAIL rstmid_regrant_wv got=%b exp=1", write_valid); end
    total++; if (grant_id !== 3'd2) begin bad++; $display("FAIL rstmid_regrant_gid got=%0d exp=2", grant_id); end
    total++; if (new_occupied_width_write !== 8'd33) begin bad++; $display("FAIL rstmid_regrant_nw got=%0d exp=33", new_occupied_width_write); end
    total++; if (grant_count !== 16'd1) begin bad++; $display("FAIL rstmid_regrant_count got=%0d exp=1", grant_count); end
  endtask

  task automatic test_sched_en();
    sched_en = 1'b0;
    set_req(1, 4'd10, 8'd0, 8'd100, 4'd0, 1'b0);
    set_req(2, 4'd11, 8'd0, 8'd110, 4'd0, 1'b0);
    set_req(3, 4'd12, 8'd0, 8'd120, 4'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL dis_ready[%0d] got=%b exp=0000", c, req_ready); end
      tick();
      total++; if (write_valid !== 1'b0) begin bad++; $display("FAIL dis_wv[%0d] got=%b exp=0", c, write_valid); end
    end
    sched_en = 1'b1;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL en_ready0 got=%b exp=1000", req_ready); end
    tick();
    clr(3);
    total++; if (grant_id !== 3'd3) begin bad++; $display("FAIL en_gid0 got=%0d exp=3", grant_id); end
    total++; if (new_occupied_width_write !== 8'd120) begin bad++; $display("FAIL en_nw0 got=%0d exp=120", new_occupied_width_write); end
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL en_ready1 got=%b exp=0010", req_ready); end
    tick();
    clr(1);
    total++; if (grant_id !== 3'd1) begin bad++; $display("FAIL en_gid1 got=%0d exp=1", grant_id); end
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL en_ready2 got=%b exp=0100", req_ready); end
    tick();
    clr(2);
    total++; if (grant_count !== 16'd4) begin bad++; $display("FAIL en_count got=%0d exp=4", grant_count); end
  endtask

  task automatic test_width_check();
    set_req(0, 4'd7, 8'd52, 8'd40, 4'd1, 1'b0);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wc_ready got=%b exp=0001", req_ready); end
    tick();
    clr(0);
    total++; if (write_valid !== 1'b1) begin bad++; $display("FAIL wc_wv got=%b exp=1", write_valid); end
    total++; if (new_occupied_width_write !== 8'd40) begin bad++; $display("FAIL wc_nw got=%0d exp=40", new_occupied_width_write); end
    total++; if (old_occupied_width_write !== 8'd52) begin bad++; $display("FAIL wc_ow got=%0d exp=52", old_occupied_width_write); end
    total++; if (err_flag !== EXP_ERR) begin bad++; $display("FAIL wc_err got=%b exp=%b", err_flag, EXP_ERR); end
    repeat (2) tick();
    total++; if (err_flag !== EXP_ERR) begin bad++; $display("FAIL wc_err_sticky got=%b exp=%b", err_flag, EXP_ERR); end
  endtask

  initial begin
    rr_strip = '{4'd2, 4'd5, 4'd8, 4'd9};
    hz_rdy   = '{4'b0001, 4'b0100, 4'b0000, 4'b0010};
    hz_wv    = '{1'b1, 1'b1, 1'b0, 1'b1};
    hz_gid   = '{3'd0, 3'd2, 3'd2, 3'd1};
    hz_strip = '{4'd5, 4'd8, 4'd8, 4'd5};
    hz_nw    = '{8'd50, 8'd80, 8'd80, 8'd51};
    hz_cnt   = '{16'd5, 16'd6, 16'd6, 16'd7};

    rst                = 1'b1;
    sched_en           = 1'b1;
    req_valid          = '0;
    req_strike_flag    = '0;
    req_strip_ID       = '0;
    req_old_width      = '0;
    req_new_width      = '0;
    req_strike_counter = '0;

    test_reset();
    test_single();
    test_round_robin();
    test_hazard();
    test_reset_mid();
    test_sched_en();
    test_width_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
